// File: rtl/iob_fir_serial_pkg.sv
// Shared FSM encoding and width helpers for the serial symmetric FIR.
package iob_fir_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_e;

  function automatic int ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int acc_width(input int din_w, input int coeff_w, input int length);
    return din_w + 1 + coeff_w + $clog2(length / 2);
  endfunction

endpackage

// File: rtl/iob_fir_round_sat.sv
// Rounds the accumulator half-up, arithmetic-shifts it right by OUT_SHIFT,
// and clamps the result to the signed output range.
module iob_fir_round_sat #(
  parameter int ACC_W      = 37,
  parameter int DATA_OUT_W = 16,
  parameter int OUT_SHIFT  = 15
) (
  input  logic signed [ACC_W-1:0]      acc_i,
  output logic        [DATA_OUT_W-1:0] data_o
);

  // One guard bit so adding the rounding term can never wrap.
  localparam int SW = ACC_W + 1;
  localparam logic signed [SW-1:0] MAX_V = {{(SW-DATA_OUT_W+1){1'b0}}, {(DATA_OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = {{(SW-DATA_OUT_W+1){1'b1}}, {(DATA_OUT_W-1){1'b0}}};

  logic signed [SW-1:0] rnd;
  logic signed [SW-1:0] biased;
  logic signed [SW-1:0] shifted;

  if (OUT_SHIFT > 0) begin : g_rnd
    assign rnd = SW'(1) << (OUT_SHIFT - 1);
  end else begin : g_no_rnd
    assign rnd = '0;
  end

  always_comb begin
    biased  = SW'(acc_i) + rnd;
    shifted = biased >>> OUT_SHIFT;
    if (shifted > MAX_V) begin
      data_o = MAX_V[DATA_OUT_W-1:0];
    end else if (shifted < MIN_V) begin
      data_o = MIN_V[DATA_OUT_W-1:0];
    end else begin
      data_o = shifted[DATA_OUT_W-1:0];
    end
  end

endmodule

// File: rtl/iob_fir_serial.sv
// Symmetric FIR, one pre-adder and one multiplier time-shared over LENGTH/2
// taps, serving NCH interleaved channels through valid/ready streams.
module iob_fir_serial
  import iob_fir_serial_pkg::*;
#(
  parameter int DATA_IN_W  = 16,
  parameter int DATA_OUT_W = 16,
  parameter int COEFF_W    = 16,
  parameter int LENGTH     = 32,
  parameter int NCH        = 1,
  parameter int OUT_SHIFT  = 15,
  localparam int CH_W      = ch_width(NCH),
  localparam int KW        = $clog2(LENGTH / 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH_W-1:0]       in_ch,
  input  logic [DATA_IN_W-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH_W-1:0]       out_ch,
  output logic [DATA_OUT_W-1:0] out_data,
  input  logic                  coeff_we,
  input  logic [KW-1:0]         coeff_addr,
  input  logic [COEFF_W-1:0]    coeff_wdata,
  output logic                  busy,
  output logic [1:0]            dbg_state_o
);

  // Streams: a beat moves on an edge where valid & ready are both high;
  // valid never waits on ready, and in_ready depends only on the FSM state.
  localparam int KN    = LENGTH / 2;
  localparam int LW    = $clog2(LENGTH);
  localparam int PW    = DATA_IN_W + 1 + COEFF_W;
  localparam int ACC_W = acc_width(DATA_IN_W, COEFF_W, LENGTH);

  fir_state_e                   state_q, state_d;
  logic [KW:0]                  k_q, k_d;
  logic [CH_W-1:0]              ch_q, ch_d, rd_ch;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic                         out_valid_q, out_valid_d;
  logic [CH_W-1:0]              out_ch_q, out_ch_d;
  logic [DATA_OUT_W-1:0]        out_data_q, out_data_d;
  logic signed [DATA_IN_W-1:0]  x_q [NCH][LENGTH];
  logic signed [COEFF_W-1:0]    h_q [KN];
  logic                         wr_ok;
  logic                         accept;
  logic [LW-1:0]                tap_lo, tap_hi;
  logic signed [DATA_IN_W-1:0]  x_lo, x_hi;
  logic signed [DATA_IN_W:0]    pre;
  logic signed [PW-1:0]         prod;
  logic [DATA_OUT_W-1:0]        rs_data;

  // Out-of-range channels are accepted but must not touch a real delay line.
  if ((1 << CH_W) > NCH) begin : g_ch_clamp
    assign wr_ok = in_ch < CH_W'(NCH);
    assign rd_ch = (ch_q < CH_W'(NCH)) ? ch_q : '0;
  end else begin : g_ch_full
    assign wr_ok = 1'b1;
    assign rd_ch = ch_q;
  end

  assign accept = (state_q == ST_IDLE) && in_valid;
  assign tap_lo = LW'(k_q[KW-1:0]);
  assign tap_hi = LW'(LENGTH - 1) - tap_lo;
  assign x_lo   = x_q[rd_ch][tap_lo];
  assign x_hi   = x_q[rd_ch][tap_hi];
  assign pre    = (DATA_IN_W+1)'(x_lo) + (DATA_IN_W+1)'(x_hi);
  assign prod   = PW'(pre) * PW'(h_q[k_q[KW-1:0]]);

  iob_fir_round_sat #(
    .ACC_W     (ACC_W),
    .DATA_OUT_W(DATA_OUT_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_round_sat (
    .acc_i (acc_q),
    .data_o(rs_data)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    ch_d        = ch_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_MAC;
          ch_d    = in_ch;
          acc_d   = '0;
          k_d     = '0;
        end
      end
      ST_MAC: begin
        // k == KN is the extra cycle that registers the finished accumulator.
        if (k_q == (KW+1)'(KN)) begin
          out_data_d  = rs_data;
          out_ch_d    = ch_q;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else begin
          acc_d = acc_q + ACC_W'(prod);
          k_d   = k_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      ch_q        <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      ch_q        <= ch_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        for (int j = 0; j < LENGTH; j++) x_q[c][j] <= '0;
      end
      for (int k = 0; k < KN; k++) h_q[k] <= '0;
    end else begin
      if ((state_q == ST_IDLE) && coeff_we) h_q[coeff_addr] <= coeff_wdata;
      for (int c = 0; c < NCH; c++) begin
        if (accept && wr_ok && (in_ch == CH_W'(c))) begin
          x_q[c][0] <= in_data;
          for (int j = 1; j < LENGTH; j++) x_q[c][j] <= x_q[c][j-1];
        end
      end
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign out_valid   = out_valid_q;
  assign out_ch      = out_ch_q;
  assign out_data    = out_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iob_fir_serial.sv
// Bench for iob_fir_serial: three instances (two-channel unshifted, shift 15,
// shift 1) checked against a direct-form convolution model.
`timescale 1ns/1ps
module tb_iob_fir_serial;

  localparam int ND = 3;
  localparam int L  = 32;
  localparam int KN = 16;

  logic                clk = 1'b0;
  logic [ND-1:0]       rst;
  logic [ND-1:0]       in_valid;
  logic [ND-1:0]       in_ready;
  logic [ND-1:0][0:0]  in_ch;
  logic [ND-1:0][15:0] in_data;
  logic [ND-1:0]       out_valid;
  logic [ND-1:0]       out_ready;
  logic [ND-1:0][0:0]  out_ch;
  logic [ND-1:0][15:0] out_data;
  logic [ND-1:0]       coeff_we;
  logic [ND-1:0][3:0]  coeff_addr;
  logic [ND-1:0][15:0] coeff_wdata;
  logic [ND-1:0]       busy;
  logic [ND-1:0][1:0]  dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  iob_fir_serial #(.NCH(2), .OUT_SHIFT(0)) u_d0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_ch(in_ch[0]), .in_data(in_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_ch(out_ch[0]), .out_data(out_data[0]),
    .coeff_we(coeff_we[0]), .coeff_addr(coeff_addr[0]), .coeff_wdata(coeff_wdata[0]),
    .busy(busy[0]), .dbg_state_o(dbg_state[0]));

  iob_fir_serial #(.NCH(1), .OUT_SHIFT(15)) u_d1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_ch(in_ch[1]), .in_data(in_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_ch(out_ch[1]), .out_data(out_data[1]),
    .coeff_we(coeff_we[1]), .coeff_addr(coeff_addr[1]), .coeff_wdata(coeff_wdata[1]),
    .busy(busy[1]), .dbg_state_o(dbg_state[1]));

  iob_fir_serial #(.NCH(1), .OUT_SHIFT(1)) u_d2 (
    .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_ch(in_ch[2]), .in_data(in_data[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_ch(out_ch[2]), .out_data(out_data[2]),
    .coeff_we(coeff_we[2]), .coeff_addr(coeff_addr[2]), .coeff_wdata(coeff_wdata[2]),
    .busy(busy[2]), .dbg_state_o(dbg_state[2]));

  // ---------------- reference model + scoreboard ----------------
  longint     hist [ND][2][L];
  longint     hc   [ND][KN];
  logic [15:0] exp_q[$];
  logic [0:0]  exp_ch_q[$];
  int checks = 0;
  int errors = 0;

  function automatic int shift_of(input int d);
    if (d == 0) return 0;
    if (d == 1) return 15;
    return 1;
  endfunction

  // Full 32-tap convolution with the mirrored coefficient set.
  function automatic longint model_y(input int d, input int ch);
    longint acc;
    int sh;
    acc = 0;
    sh  = shift_of(d);
    for (int j = 0; j < L; j++) acc += hist[d][ch][j] * hc[d][(j < KN) ? j : (L - 1 - j)];
    if (sh > 0) acc = (acc + (longint'(1) <<< (sh - 1))) >>> sh;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  function automatic void model_push(input int d, input int ch, input int val);
    for (int j = L - 1; j > 0; j--) hist[d][ch][j] = hist[d][ch][j-1];
    hist[d][ch][0] = longint'(val);
  endfunction

  function automatic void model_reset(input int d);
    for (int c = 0; c < 2; c++)
      for (int j = 0; j < L; j++) hist[d][c][j] = 0;
    for (int k = 0; k < KN; k++) hc[d][k] = 0;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sdata(input int d);
    return longint'($signed(out_data[d]));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_dut(input int d);
    rst[d] = 1'b1;
    step();
    step();
    rst[d] = 1'b0;
    model_reset(d);
  endtask

  task automatic wr_coeff(input int d, input int k, input int v);
    coeff_we[d]    = 1'b1;
    coeff_addr[d]  = 4'(k);
    coeff_wdata[d] = 16'(v);
    step();
    coeff_we[d] = 1'b0;
    hc[d][k]    = longint'(v);
  endtask

  // One full transaction: accept a sample (optionally with a coefficient
  // write in the same cycle, or one while busy), wait for the result, hold
  // off the consumer for `hold` cycles, then take the result.
  task automatic xact(input int d, input int ch, input int val, input int hold,
                      input bit acc_wr, input int wk, input int wv, input bit mid_wr,
                      output longint got, output int lat);
    int n;
    logic [15:0] snap_d;
    logic [0:0]  snap_c;
    logic [15:0] e_d;
    logic [0:0]  e_c;
    n = 0;
    while (!in_ready[d] && n < 50) begin
      step();
      n++;
    end
    check("in_ready_bound", longint'(n < 50), 1);
    if (acc_wr) begin
      coeff_we[d]    = 1'b1;
      coeff_addr[d]  = 4'(wk);
      coeff_wdata[d] = 16'(wv);
      hc[d][wk]      = longint'(wv);
    end
    model_push(d, ch, val);
    exp_q.push_back(16'(model_y(d, ch)));
    exp_ch_q.push_back(1'(ch));
    in_valid[d] = 1'b1;
    in_ch[d]    = 1'(ch);
    in_data[d]  = 16'(val);
    step();
    in_valid[d] = 1'b0;
    coeff_we[d] = 1'b0;
    lat = 0;
    while (!out_valid[d] && lat < 100) begin
      if (mid_wr && lat == 3) begin
        coeff_we[d]    = 1'b1;
        coeff_addr[d]  = 4'd0;
        coeff_wdata[d] = 16'd5;
      end else begin
        coeff_we[d] = 1'b0;
      end
      step();
      lat++;
    end
    coeff_we[d] = 1'b0;
    check("out_valid_bound", longint'(lat < 100), 1);
    snap_d = out_data[d];
    snap_c = out_ch[d];
    for (int i = 0; i < hold; i++) begin
      step();
      check("bp_data_stable", longint'(out_data[d]), longint'(snap_d));
      check("bp_ch_stable", longint'(out_ch[d]), longint'(snap_c));
      check("bp_valid_held", longint'(out_valid[d]), 1);
      check("bp_in_ready_low", longint'(in_ready[d]), 0);
    end
    e_d = exp_q.pop_front();
    e_c = exp_ch_q.pop_front();
    check("sb_data", sdata(d), longint'($signed(e_d)));
    check("sb_ch", longint'(out_ch[d]), longint'(e_c));
    got = sdata(d);
    out_ready[d] = 1'b1;
    step();
    out_ready[d] = 1'b0;
    check("post_hs_valid", longint'(out_valid[d]), 0);
    check("post_hs_in_ready", longint'(in_ready[d]), 1);
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    int val;
    int exp;
  } vec_t;

  vec_t   rnd_tab[10];
  longint got;
  int     lat;
  int     seen;

  initial begin
    rst         = '1;
    in_valid    = '0;
    in_ch       = '0;
    in_data     = '0;
    out_ready   = '0;
    coeff_we    = '0;
    coeff_addr  = '0;
    coeff_wdata = '0;
    for (int d = 0; d < ND; d++) model_reset(d);
    repeat (3) step();
    for (int d = 0; d < ND; d++) begin
      check("rst_in_ready", longint'(in_ready[d]), 1);
      check("rst_out_valid", longint'(out_valid[d]), 0);
      check("rst_out_ch", longint'(out_ch[d]), 0);
      check("rst_out_data", longint'(out_data[d]), 0);
      check("rst_busy", longint'(busy[d]), 0);
      check("rst_state", longint'(dbg_state[d]), 0);
    end
    rst = '0;
    step();

    // Rounding table, shift 1, h[0]=1: half-up on the pre-shift value.
    rnd_tab[0] = '{3, 2};
    rnd_tab[1] = '{-3, -1};
    rnd_tab[2] = '{1, 1};
    rnd_tab[3] = '{-1, 0};
    rnd_tab[4] = '{0, 0};
    rnd_tab[5] = '{100, 50};
    rnd_tab[6] = '{-101, -50};
    rnd_tab[7] = '{32767, 16384};
    rnd_tab[8] = '{-32768, -16384};
    rnd_tab[9] = '{5, 3};
    wr_coeff(2, 0, 1);
    for (int i = 0; i < 10; i++) begin
      xact(2, 0, rnd_tab[i].val, 0, 1'b0, 0, 0, 1'b0, got, lat);
      check("round_tab", got, longint'(rnd_tab[i].exp));
    end

    // Impulse, h[k]=k+1, shift 0.
    for (int k = 0; k < KN; k++) wr_coeff(0, k, k + 1);
    for (int n = 0; n < 33; n++) begin
      xact(0, 0, (n == 0) ? 1 : 0, 0, 1'b0, 0, 0, 1'b0, got, lat);
      check("impulse", got, longint'((n < 16) ? n + 1 : ((n < 32) ? 32 - n : 0)));
      check("latency", longint'(lat), longint'(KN + 1));
    end

    // Two channels interleaved, h=1, with one long backpressure stall.
    rst_dut(0);
    for (int k = 0; k < KN; k++) wr_coeff(0, k, 1);
    for (int n = 0; n < 33; n++) begin
      xact(0, 0, (n == 0) ? 1 : 0, 0, 1'b0, 0, 0, 1'b0, got, lat);
      check("mc_ch0", got, longint'((n < 32) ? 1 : 0));
      xact(0, 1, 2, (n == 5) ? 10 : 0, 1'b0, 0, 0, 1'b0, got, lat);
      check("mc_ch1", got, longint'(2 * ((n + 1 < 32) ? n + 1 : 32)));
    end

    // Saturation, shift 15, all h=32767.
    for (int k = 0; k < KN; k++) wr_coeff(1, k, 32767);
    for (int n = 0; n < 32; n++) xact(1, 0, 32767, 0, 1'b0, 0, 0, 1'b0, got, lat);
    check("sat_pos", got, 32767);
    for (int n = 0; n < 32; n++) xact(1, 0, -32768, 0, 1'b0, 0, 0, 1'b0, got, lat);
    check("sat_neg", got, -32768);

    // Coefficient write while busy is dropped; write with accept is used.
    rst_dut(0);
    wr_coeff(0, 0, 7);
    xact(0, 0, 1, 0, 1'b0, 0, 0, 1'b1, got, lat);
    check("busy_wr_ignored", got, 7);
    xact(0, 0, 1, 0, 1'b0, 0, 0, 1'b0, got, lat);
    check("busy_wr_reread", got, 7);
    xact(0, 0, 1, 0, 1'b1, 0, 9, 1'b0, got, lat);
    check("same_cycle_wr", got, 9);

    // Reset in the middle of MAC aborts the result and clears h[].
    in_valid[0] = 1'b1;
    in_ch[0]    = 1'b0;
    in_data[0]  = 16'd1000;
    step();
    in_valid[0] = 1'b0;
    repeat (5) step();
    check("mid_mac_busy", longint'(busy[0]), 1);
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    model_reset(0);
    check("abort_in_ready", longint'(in_ready[0]), 1);
    check("abort_busy", longint'(busy[0]), 0);
    check("abort_out_valid", longint'(out_valid[0]), 0);
    check("abort_out_data", longint'(out_data[0]), 0);
    seen = 0;
    repeat (30) begin
      step();
      if (out_valid[0]) seen = 1;
    end
    check("no_stale_out", longint'(seen), 0);
    for (int n = 0; n < 4; n++) begin
      xact(0, 0, (n == 0) ? 1 : 0, 0, 1'b0, 0, 0, 1'b0, got, lat);
      check("post_rst_zero", got, 0);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < KN; k++) wr_coeff(0, k, int'($urandom_range(0, 32)) - 16);
    repeat (60) begin
      xact(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 4095)) - 2048,
           int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 32)) - 16, 1'b0, got, lat);
    end
    for (int k = 0; k < KN; k++) wr_coeff(1, k, int'($urandom_range(0, 65535)) - 32768);
    repeat (60) begin
      xact(1, 0, int'($urandom_range(0, 65535)) - 32768,
           int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)) - 32768,
           ($urandom_range(0, 9) == 0), got, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
